// File: rtl/axi_s_pkt_master.sv
// AXI-Stream byte master: buffers producer bytes in a first-word fall-through FIFO and,
// on a start command, emits one packet of pkt_len beats with m_tlast on the final beat.
module axi_s_pkt_master #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int LEN_W  = 8
) (
    input  logic                       s_aclk,
    input  logic                       s_resetn,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       overflow,
    input  logic                       start,
    input  logic [LEN_W-1:0]           pkt_len,
    output logic                       busy,
    output logic                       done,
    output logic                       m_tvalid,
    input  logic                       m_tready,
    output logic [DATA_W-1:0]          m_tdata,
    output logic                       m_tlast
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [LW-1:0]     count;
    logic              push;
    logic              pop;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              last_beat;

    assign full     = (count == LW'(DEPTH));
    assign level    = count;
    assign push     = wr_en && !full;
    assign pop      = m_tvalid && m_tready;
    // A write while full is dropped regardless of a pop in the same cycle.
    assign overflow = wr_en && full;

    // NOTE: the storage array carries no reset; validity is defined by the pointers and count,
    // which keeps the array mappable onto plain RAM.
    always_ff @(posedge s_aclk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: clocked state is updated only with non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge s_aclk) begin
        if (!s_resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    // Stream outputs never look at m_tready; they hold until the handshake because the
    // head entry and the beat counter only move on a pop.
    assign busy      = (state_q == SEND);
    assign m_tvalid  = busy && (count != '0);
    assign last_beat = (cnt_q == len_q - LEN_W'(1));
    assign m_tlast   = m_tvalid && last_beat;
    assign m_tdata   = m_tvalid ? mem[rd_ptr] : '0;
    assign done      = done_q;

    always_ff @(posedge s_aclk) begin
        if (!s_resetn) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && (pkt_len != '0)) begin
                    state_d = SEND;
                    len_d   = pkt_len;
                    cnt_d   = '0;
                end
            end
            SEND: begin
                if (pop) begin
                    if (last_beat) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d   = cnt_q + LEN_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifndef SYNTHESIS
    a_hold_until_handshake: assert property (@(posedge s_aclk) disable iff (!s_resetn)
        (m_tvalid && !m_tready) |=> (m_tvalid && $stable(m_tdata) && $stable(m_tlast)));

    a_level_bound: assert property (@(posedge s_aclk) disable iff (!s_resetn)
        (count <= LW'(DEPTH)));
`endif

endmodule

// File: tb/tb_axi_s_pkt_master.sv
// Bench for axi_s_pkt_master: directed scenarios pinned by literal expectations plus a
// randomized run, all outputs compared every cycle against a queue-based packet model.
module tb_axi_s_pkt_master;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int LEN_W  = 8;
    localparam int LW     = $clog2(DEPTH+1);

    logic              s_aclk   = 1'b0;
    logic              s_resetn = 1'b0;
    logic              wr_en    = 1'b0;
    logic [DATA_W-1:0] wr_data  = '0;
    logic              start    = 1'b0;
    logic [LEN_W-1:0]  pkt_len  = '0;
    logic              m_tready = 1'b0;
    logic              full;
    logic [LW-1:0]     level;
    logic              overflow;
    logic              busy;
    logic              done;
    logic              m_tvalid;
    logic [DATA_W-1:0] m_tdata;
    logic              m_tlast;

    axi_s_pkt_master #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .s_aclk   (s_aclk),
        .s_resetn (s_resetn),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .level    (level),
        .overflow (overflow),
        .start    (start),
        .pkt_len  (pkt_len),
        .busy     (busy),
        .done     (done),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tdata  (m_tdata),
        .m_tlast  (m_tlast)
    );

    always #5 s_aclk = ~s_aclk;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Packet model: FIFO contents as a queue, packet progress as beats sent out of a length.
    logic [DATA_W-1:0] mq[$];
    bit m_send = 1'b0;
    int m_len  = 0;
    int m_cnt  = 0;
    bit m_done = 1'b0;

    always @(posedge s_aclk) begin : model
        bit was_send;
        bit was_full;
        bit hs;
        if (!s_resetn) begin
            mq.delete();
            m_send = 1'b0;
            m_len  = 0;
            m_cnt  = 0;
            m_done = 1'b0;
        end else begin
            was_send = m_send;
            was_full = (mq.size() == DEPTH);
            hs       = m_send && (mq.size() != 0) && m_tready;
            m_done   = 1'b0;
            if (hs) begin
                void'(mq.pop_front());
                m_cnt++;
                if (m_cnt == m_len) begin
                    m_send = 1'b0;
                    m_done = 1'b1;
                end
            end
            if (wr_en && !was_full) mq.push_back(wr_data);
            if (!was_send && start && (pkt_len != 0)) begin
                m_send = 1'b1;
                m_len  = int'(pkt_len);
                m_cnt  = 0;
            end
        end
    end

    always @(negedge s_aclk) begin : compare
        bit ev;
        if (cmp_en) begin
            ev = m_send && (mq.size() != 0);
            check("level",    level,    mq.size());
            check("full",     full,     mq.size() == DEPTH);
            check("overflow", overflow, wr_en && (mq.size() == DEPTH));
            check("busy",     busy,     m_send);
            check("done",     done,     m_done);
            check("tvalid",   m_tvalid, ev);
            check("tdata",    m_tdata,  ev ? mq[0] : 8'h00);
            check("tlast",    m_tlast,  ev && (m_cnt == m_len - 1));
        end
    end

    // Observed-beat log for the literal expectations of the directed scenarios.
    logic [DATA_W-1:0] got[$];
    bit got_last[$];
    int n_ovf    = 0;
    int n_done   = 0;
    int n_bubble = 0;
    int n_stall  = 0;

    always @(negedge s_aclk) begin : collect
        if (cmp_en && s_resetn) begin
            if (m_tvalid && m_tready) begin
                got.push_back(m_tdata);
                got_last.push_back(m_tlast);
            end
            if (overflow) n_ovf++;
            if (done) n_done++;
            if (busy && !m_tvalid) n_bubble++;
            if (m_tvalid && !m_tready) n_stall++;
        end
    end

    task automatic tick();
        @(posedge s_aclk);
        #1;
    endtask

    task automatic do_reset();
        s_resetn = 1'b0;
        wr_en    = 1'b0;
        start    = 1'b0;
        m_tready = 1'b0;
        tick();
        cmp_en   = 1'b1;
        tick();
        s_resetn = 1'b1;
        got.delete();
        got_last.delete();
        n_ovf    = 0;
        n_done   = 0;
        n_bubble = 0;
        n_stall  = 0;
    endtask

    task automatic push_byte(input logic [DATA_W-1:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic start_pkt(input int len);
        start   = 1'b1;
        pkt_len = LEN_W'(len);
        tick();
        start   = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget, output int cycles);
        cycles = 0;
        while (!done && cycles < budget) begin
            tick();
            cycles++;
        end
        check(name, done, 1'b1);
    endtask

    task automatic check_got(input string name, input int idx, input logic [DATA_W-1:0] exp,
                             input bit exp_last);
        if (idx < got.size()) begin
            check(name, got[idx], exp);
            check({name, "_last"}, got_last[idx], exp_last);
        end else begin
            check({name, "_missing"}, got.size(), idx + 1);
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin : stim
        logic [DATA_W-1:0] t1[4];
        bit pat[4];
        int cyc;
        t1  = '{8'h11, 8'h22, 8'h33, 8'h44};
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};

        // Reset state.
        do_reset();
        check("rst_level", level, 0);
        check("rst_full", full, 0);
        check("rst_tvalid", m_tvalid, 0);
        check("rst_tdata", m_tdata, 0);
        check("rst_busy", busy, 0);

        // Back-to-back beats with tlast on the fourth, done one cycle later.
        for (int i = 0; i < 4; i++) push_byte(t1[i]);
        m_tready = 1'b1;
        start_pkt(4);
        wait_done("t1_done", 20, cyc);
        check("t1_latency", cyc, 4);
        check("t1_count", got.size(), 4);
        for (int i = 0; i < 4; i++) check_got("t1_beat", i, t1[i], i == 3);
        check("t1_level", level, 0);
        tick();
        check("t1_done_pulse", done, 0);

        // Ready pattern 1,0,0,1 stalls the stream.
        do_reset();
        for (int i = 0; i < 4; i++) push_byte(t1[i]);
        start_pkt(4);
        for (int c = 0; c < 40 && !done; c++) begin
            m_tready = pat[c % 4];
            tick();
        end
        m_tready = 1'b0;
        check("t2_done", done, 1);
        check("t2_count", got.size(), 4);
        for (int i = 0; i < 4; i++) check_got("t2_beat", i, t1[i], i == 3);
        check("t2_stalled", n_stall > 0, 1);

        // Empty FIFO mid-packet produces bubbles.
        do_reset();
        push_byte(8'hA1);
        m_tready = 1'b1;
        start_pkt(3);
        repeat (5) tick();
        push_byte(8'hA2);
        push_byte(8'hA3);
        wait_done("t3_done", 20, cyc);
        check("t3_count", got.size(), 3);
        check_got("t3_beat0", 0, 8'hA1, 1'b0);
        check_got("t3_beat1", 1, 8'hA2, 1'b0);
        check_got("t3_beat2", 2, 8'hA3, 1'b1);
        check("t3_bubble", n_bubble > 0, 1);

        // Seventeen writes into sixteen entries.
        do_reset();
        for (int k = 1; k <= 16; k++) push_byte(DATA_W'(k));
        check("t4_full", full, 1);
        check("t4_level16", level, 16);
        wr_en   = 1'b1;
        wr_data = 8'd17;
        #1;
        check("t4_ovf_now", overflow, 1);
        tick();
        wr_en = 1'b0;
        #1;
        check("t4_ovf_gone", overflow, 0);
        check("t4_level_kept", level, 16);
        check("t4_ovf_cycles", n_ovf, 1);
        m_tready = 1'b1;
        start_pkt(16);
        wait_done("t4_done", 40, cyc);
        check("t4_count", got.size(), 16);
        for (int k = 1; k <= 16; k++) check_got("t4_beat", k - 1, DATA_W'(k), k == 16);

        // Zero-length start is ignored; reset mid-packet aborts without tlast.
        do_reset();
        start_pkt(0);
        repeat (3) tick();
        check("t5_idle_busy", busy, 0);
        check("t5_no_done", n_done, 0);
        for (int k = 0; k < 5; k++) push_byte(DATA_W'(8'h50 + k));
        m_tready = 1'b1;
        start_pkt(5);
        tick();
        tick();
        check("t5_two_beats", got.size(), 2);
        s_resetn = 1'b0;
        m_tready = 1'b0;
        tick();
        check("t5_rst_tvalid", m_tvalid, 0);
        check("t5_rst_level", level, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_no_tlast", (got_last.size() == 2) && !got_last[0] && !got_last[1], 1);
        s_resetn = 1'b1;

        // Push while full with a concurrent pop, then steady push+pop at level 5.
        do_reset();
        for (int k = 0; k < 16; k++) push_byte(DATA_W'(8'h60 + k));
        start_pkt(20);
        wr_en    = 1'b1;
        wr_data  = 8'hEE;
        m_tready = 1'b1;
        #1;
        check("t6_ovf_with_pop", overflow, 1);
        tick();
        wr_en    = 1'b0;
        m_tready = 1'b0;
        check("t6_level15", level, 15);
        do_reset();
        for (int k = 0; k < 5; k++) push_byte(DATA_W'(8'h40 + k));
        start_pkt(45);
        for (int c = 0; c < 40; c++) begin
            wr_en    = 1'b1;
            wr_data  = DATA_W'(8'h80 + c);
            m_tready = 1'b1;
            tick();
            check("t6_level5", level, 5);
        end
        wr_en = 1'b0;
        wait_done("t6_done", 20, cyc);
        m_tready = 1'b0;
        check("t6_count", got.size(), 45);
        for (int k = 0; k < 5; k++) check_got("t6_head", k, DATA_W'(8'h40 + k), 1'b0);
        for (int c = 0; c < 40; c++) check_got("t6_wrap", c + 5, DATA_W'(8'h80 + c), c == 39);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            wr_en    = ($urandom_range(0, 99) < 55);
            wr_data  = DATA_W'($urandom);
            m_tready = ($urandom_range(0, 99) < 70);
            start    = ($urandom_range(0, 99) < 15);
            pkt_len  = ($urandom_range(0, 9) == 0) ? '0 : LEN_W'($urandom_range(1, 24));
            s_resetn = ($urandom_range(0, 999) != 0);
            tick();
        end
        s_resetn = 1'b1;
        wr_en    = 1'b0;
        start    = 1'b0;
        m_tready = 1'b0;
        tick();
        check("rand_packets_done", n_done > 0, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
